// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_det
// Description : Two-flop synchroniser plus delay flop for one asynchronous
//               input; emits the synchronised level and one-cycle rise/fall.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign level_o = s2_q;
  assign rise_o  = s2_q & ~s3_q;
  assign fall_o  = ~s2_q & s3_q;

endmodule
`default_nettype wire

// File: rtl/pwm_meter.sv
`default_nettype none
// ============================================================================
// Module      : pwm_meter
// Description : Measures period and high time of one asynchronous PWM input
//               in clk cycles and flags inputs stuck high or stuck low.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_meter #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_vld,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

  logic             w_level;
  logic             w_rise;
  logic             w_fall;
  logic             w_timeout;
  logic [CNT_W:0]   w_sum;
  logic [CNT_W-1:0] w_period;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [CNT_W-1:0] high_latch_q, high_latch_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic [CNT_W-1:0] high_q,       high_d;
  logic             vld_q,        vld_d;
  logic             stuck_hi_q,   stuck_hi_d;
  logic             stuck_lo_q,   stuck_lo_d;

  sync_edge_det u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (pwm_in),
    .level_o (w_level),
    .rise_o  (w_rise),
    .fall_o  (w_fall)
  );

  assign w_timeout = (cnt_q == c_timeout);

  // cnt restarts on every edge, so at the closing rise it holds only the low
  // time; the full period is the latched high time plus that low time.
  assign w_sum    = {1'b0, high_latch_q} + {1'b0, cnt_q};
  assign w_period = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (w_rise || w_fall) begin
      cnt_d = c_one;
    end else if (cnt_q < c_timeout) begin
      cnt_d = cnt_q + c_one;
    end
  end

  always_comb begin
    state_d      = state_q;
    high_latch_d = high_latch_q;
    period_d     = period_q;
    high_d       = high_q;
    vld_d        = 1'b0;
    stuck_hi_d   = stuck_hi_q;
    stuck_lo_d   = stuck_lo_q;

    if (w_rise || w_fall) begin
      stuck_hi_d = 1'b0;
      stuck_lo_d = 1'b0;
    end

    // Edges are tested before the timeout so a coincident edge always wins.
    case (state_q)
      IDLE: begin
        if (w_rise) begin
          state_d = HIGH;
        end else if (!w_fall && w_timeout) begin
          stuck_hi_d = w_level;
          stuck_lo_d = ~w_level;
        end
      end
      HIGH: begin
        if (w_fall) begin
          state_d      = LOW;
          high_latch_d = cnt_q;
        end else if (!w_rise && w_timeout) begin
          stuck_hi_d = 1'b1;
          stuck_lo_d = 1'b0;
          state_d    = IDLE;
        end
      end
      LOW: begin
        if (w_rise) begin
          state_d  = HIGH;
          period_d = w_period;
          high_d   = high_latch_q;
          vld_d    = 1'b1;
        end else if (!w_fall && w_timeout) begin
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      high_latch_q <= '0;
      period_q     <= '0;
      high_q       <= '0;
      vld_q        <= 1'b0;
      stuck_hi_q   <= 1'b0;
      stuck_lo_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      high_latch_q <= high_latch_d;
      period_q     <= period_d;
      high_q       <= high_d;
      vld_q        <= vld_d;
      stuck_hi_q   <= stuck_hi_d;
      stuck_lo_q   <= stuck_lo_d;
    end
  end

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign meas_vld   = vld_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_meter
// Description : Scoreboard bench for pwm_meter (TIMEOUT = 1000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_meter;

  localparam int CNT_W   = 24;
  localparam int TIMEOUT = 1000;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             meas_vld;
  logic             stuck_hi;
  logic             stuck_lo;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t e_mon;
  bit   have_prev = 1'b0;
  int   last_h = 0;
  int   last_l = 0;

  pwm_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .meas_vld   (meas_vld),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  always #20 clk = ~clk;

  // Output side of the scoreboard: every meas_vld must match the oldest entry.
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (stuck_hi && stuck_lo) begin
        n_fail++;
        $display("FAIL flags_exclusive: stuck_hi=%0b stuck_lo=%0b, required not both 1", stuck_hi, stuck_lo);
      end
      if (meas_vld) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_meas_vld: period_cnt=%0d high_cnt=%0d, required no pulse", period_cnt, high_cnt);
        end else begin
          e_mon = exp_q.pop_front();
          if (period_cnt !== e_mon.period || high_cnt !== e_mon.high) begin
            n_fail++;
            $display("FAIL measurement: period_cnt=%0d high_cnt=%0d, required period_cnt=%0d high_cnt=%0d",
                     period_cnt, high_cnt, e_mon.period, e_mon.high);
          end
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Input side: a rise that closes a previous period predicts one measurement.
  task automatic drive_rise();
    if (have_prev) exp_q.push_back('{period: CNT_W'(last_h + last_l), high: CNT_W'(last_h)});
    pwm_in = 1'b1;
  endtask

  task automatic pulse(input int h, input int l);
    drive_rise();
    wait_cycles(h);
    pwm_in = 1'b0;
    wait_cycles(l);
    last_h    = h;
    last_l    = l;
    have_prev = 1'b1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    have_prev = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_drained(input string name);
    wait_cycles(10);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL %s_drained: %0d measurements outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #5;
    n_checks += 5;
    if (period_cnt !== '0) begin n_fail++; $display("FAIL reset_period: %0d, required 0", period_cnt); end
    if (high_cnt !== '0)   begin n_fail++; $display("FAIL reset_high: %0d, required 0", high_cnt); end
    if (meas_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: %0b, required 0", meas_vld); end
    if (stuck_hi !== 1'b0) begin n_fail++; $display("FAIL reset_stuck_hi: %0b, required 0", stuck_hi); end
    if (stuck_lo !== 1'b0) begin n_fail++; $display("FAIL reset_stuck_lo: %0b, required 0", stuck_lo); end
    do_reset();
  endtask

  task automatic test_basic_25_75();
    do_reset();
    repeat (6) pulse(25, 75);
    check_drained("basic_25_75");
  endtask

  task automatic test_back_to_back_min();
    do_reset();
    repeat (10) pulse(1, 3);
    check_drained("min_1_3");
  endtask

  task automatic test_stuck_hi();
    int t;
    do_reset();
    repeat (10) pulse(25, 75);
    drive_rise();
    have_prev = 1'b0;
    t = 0;
    while (!stuck_hi && t < 1200) begin
      wait_cycles(1);
      t++;
    end
    n_checks += 4;
    if (t < 1001 || t > 1005) begin n_fail++; $display("FAIL stuck_hi_delay: %0d cycles, required 1001..1005", t); end
    if (stuck_lo !== 1'b0)  begin n_fail++; $display("FAIL stuck_hi_lo_clear: stuck_lo=%0b, required 0", stuck_lo); end
    if (period_cnt !== 100) begin n_fail++; $display("FAIL stuck_hi_period_hold: %0d, required 100", period_cnt); end
    if (high_cnt !== 25)    begin n_fail++; $display("FAIL stuck_hi_high_hold: %0d, required 25", high_cnt); end
    pwm_in = 1'b0;
    wait_cycles(6);
    n_checks++;
    if (stuck_hi !== 1'b0) begin n_fail++; $display("FAIL stuck_hi_clear: %0b, required 0", stuck_hi); end
    wait_cycles(44);
    pulse(30, 70);
    pulse(30, 70);
    check_drained("stuck_hi_recover");
  endtask

  task automatic test_stuck_lo();
    int t;
    do_reset();
    t = 0;
    while (!stuck_lo && t < 1200) begin
      wait_cycles(1);
      t++;
    end
    n_checks += 2;
    if (t < 996 || t > 1002) begin n_fail++; $display("FAIL stuck_lo_delay: %0d cycles, required 996..1002", t); end
    if (stuck_hi !== 1'b0)   begin n_fail++; $display("FAIL stuck_lo_hi_clear: stuck_hi=%0b, required 0", stuck_hi); end
    wait_cycles(20);
    n_checks++;
    if (stuck_lo !== 1'b1) begin n_fail++; $display("FAIL stuck_lo_level: %0b, required 1", stuck_lo); end
  endtask

  task automatic test_reset_mid_high();
    do_reset();
    pulse(25, 75);
    pulse(25, 75);
    drive_rise();
    have_prev = 1'b0;
    wait_cycles(10);
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL pre_reset_drained: %0d outstanding, required 0", exp_q.size()); end
    #6;
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    n_checks += 3;
    if (period_cnt !== '0) begin n_fail++; $display("FAIL async_reset_period: %0d, required 0", period_cnt); end
    if (high_cnt !== '0)   begin n_fail++; $display("FAIL async_reset_high: %0d, required 0", high_cnt); end
    if (stuck_hi !== 1'b0 || meas_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_flags: stuck_hi=%0b meas_vld=%0b, required 0 0", stuck_hi, meas_vld);
    end
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    wait_cycles(5);
    pulse(40, 60);
    pulse(40, 60);
    pulse(40, 60);
    check_drained("after_async_reset");
  endtask

  task automatic test_duty_sweep();
    int t;
    do_reset();
    for (int d = 10; d <= 90; d += 10) pulse(d, 100 - d);
    pulse(50, 50);
    check_drained("duty_sweep");

    do_reset();
    t = 0;
    while (!stuck_lo && t < 1200) begin
      wait_cycles(1);
      t++;
    end
    n_checks++;
    if (stuck_lo !== 1'b1 || stuck_hi !== 1'b0) begin
      n_fail++;
      $display("FAIL duty_0: stuck_lo=%0b stuck_hi=%0b, required 1 0", stuck_lo, stuck_hi);
    end

    do_reset();
    drive_rise();
    t = 0;
    while (!stuck_hi && t < 1200) begin
      wait_cycles(1);
      t++;
    end
    n_checks += 2;
    if (stuck_hi !== 1'b1 || stuck_lo !== 1'b0) begin
      n_fail++;
      $display("FAIL duty_100: stuck_hi=%0b stuck_lo=%0b, required 1 0", stuck_hi, stuck_lo);
    end
    if (period_cnt !== '0 || high_cnt !== '0) begin
      n_fail++;
      $display("FAIL duty_100_outputs: period_cnt=%0d high_cnt=%0d, required 0 0", period_cnt, high_cnt);
    end
    pwm_in = 1'b0;
    check_drained("duty_100");
  endtask

  initial begin
    test_reset();
    test_basic_25_75();
    test_back_to_back_min();
    test_stuck_hi();
    test_stuck_lo();
    test_reset_mid_high();
    test_duty_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
